rip_mem_port_arbiter: RTL and testbench

Arbitrates two cache-side memory requesters onto the single downstream AXI master adapter inside the MMU. Port 1 is the data channel (read or write-back); port 2 is the instruction channel (read only). Exactly one transaction is outstanding at a time. Round-robin priority prevents starvation and lets neither channel deadlock behind the other. The block sits between the cache miss handlers and the AXI burst engine.

---
 rtl/rip_mem_port_arbiter.sv | 99 +++++++++
 tb/tb_rip_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rip_mem_port_arbiter.sv
// rip_mem_port_arbiter: round-robin arbiter of two cache requesters onto one memory master
module rip_mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE = 4,
    localparam int LW = LINE_SIZE * 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [LW-1:0]         p1_wdata,
    input  logic [LINE_SIZE-1:0]  p1_wstrb,
    output logic                  p1_gnt,
    output logic                  p1_busy,
    output logic                  p1_rvalid,
    output logic [LW-1:0]         p1_rdata,
    input  logic                  p2_req,
    input  logic [ADDR_WIDTH-1:0] p2_addr,
    output logic                  p2_gnt,
    output logic                  p2_busy,
    output logic                  p2_rvalid,
    output logic [LW-1:0]         p2_rdata,
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [LW-1:0]         m_wdata,
    output logic [LINE_SIZE-1:0]  m_wstrb,
    input  logic                  m_ack,
    input  logic                  m_done,
    input  logic [LW-1:0]         m_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state;
    logic ptr;
    logic owner;
    logic sel2;
    // port 2 wins when it is the only requester or when the pointer favours it
    assign sel2 = p2_req & (~p1_req | ptr);
    // single transaction FSM; every output is registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            p1_gnt    <= 1'b0;
            p1_busy   <= 1'b0;
            p1_rvalid <= 1'b0;
            p1_rdata  <= '0;
            p2_gnt    <= 1'b0;
            p2_busy   <= 1'b0;
            p2_rvalid <= 1'b0;
            p2_rdata  <= '0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
        end else begin
            p1_gnt    <= 1'b0;
            p2_gnt    <= 1'b0;
            p1_rvalid <= 1'b0;
            p2_rvalid <= 1'b0;
            case (state)
                IDLE: if (p1_req | p2_req) begin
                    owner   <= sel2;
                    ptr     <= ~sel2;
                    m_req   <= 1'b1;
                    m_we    <= ~sel2 & p1_we;
                    m_addr  <= sel2 ? p2_addr : p1_addr;
                    m_wdata <= sel2 ? '0 : p1_wdata;
                    m_wstrb <= (~sel2 & p1_we) ? p1_wstrb : '0;
                    p1_gnt  <= ~sel2;
                    p2_gnt  <= sel2;
                    p1_busy <= ~sel2;
                    p2_busy <= sel2;
                    state   <= ISSUE;
                end
                ISSUE: if (m_ack) begin
                    m_req <= 1'b0;
                    state <= WAIT;
                end
                WAIT: if (m_done) begin
                    if (owner) begin
                        p2_rdata  <= m_rdata;
                        p2_rvalid <= 1'b1;
                        p2_busy   <= 1'b0;
                    end else begin
                        p1_rdata  <= m_rdata;
                        p1_rvalid <= 1'b1;
                        p1_busy   <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rip_mem_port_arbiter.sv
// tb_rip_mem_port_arbiter: directed vector table plus multi-cycle sequences for the arbiter
module tb_rip_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst, p1_req, p1_we, p2_req, m_ack, m_done;
    logic [31:0] p1_addr, p1_wdata, p2_addr, m_rdata;
    logic [3:0]  p1_wstrb;
    logic        p1_gnt, p1_busy, p1_rvalid, p2_gnt, p2_busy, p2_rvalid;
    logic        m_req, m_we;
    logic [31:0] p1_rdata, p2_rdata, m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    int n_cmp = 0;
    int n_bad = 0;

    rip_mem_port_arbiter #(.ADDR_WIDTH(32), .LINE_SIZE(4)) dut (
        .clk(clk), .rst(rst),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
        .p1_gnt(p1_gnt), .p1_busy(p1_busy), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .p2_req(p2_req), .p2_addr(p2_addr),
        .p2_gnt(p2_gnt), .p2_busy(p2_busy), .p2_rvalid(p2_rvalid), .p2_rdata(p2_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ack(m_ack), .m_done(m_done), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // ctl = {rst, p1_req, p1_we, p2_req, m_ack, m_done}
    // flg = {p1_gnt, p2_gnt, p1_busy, p2_busy, p1_rvalid, p2_rvalid, m_req, m_we}
    typedef struct {
        logic [5:0]  ctl;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] mrd;
        logic [7:0]  flg;
        logic [31:0] maddr;
        logic [3:0]  mws;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } vec_t;
    vec_t tbl[16];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 1'b0; p1_req = 1'b0; p1_we = 1'b0; p2_req = 1'b0;
        m_ack = 1'b0; m_done = 1'b0; m_rdata = '0;
    endtask

    initial begin
        int gnt_seen;
        tbl[0]  = '{6'b111000, 32'h10, 32'h0,  32'h0,        8'b00000000, 32'h10, 4'h0, 32'h0,        32'h0};
        tbl[1]  = tbl[0];
        tbl[2]  = tbl[0];
        tbl[3]  = tbl[0];
        tbl[4]  = tbl[0];
        tbl[5]  = '{6'b011000, 32'h10, 32'h0,  32'h0,        8'b10100011, 32'h10, 4'hf, 32'h0,        32'h0};
        tbl[6]  = '{6'b000000, 32'h10, 32'h0,  32'h0,        8'b00100011, 32'h10, 4'hf, 32'h0,        32'h0};
        tbl[7]  = '{6'b000010, 32'h10, 32'h0,  32'h0,        8'b00100000, 32'h10, 4'hf, 32'h0,        32'h0};
        tbl[8]  = '{6'b000000, 32'h10, 32'h0,  32'h0,        8'b00100000, 32'h10, 4'hf, 32'h0,        32'h0};
        tbl[9]  = tbl[8];
        tbl[10] = '{6'b000001, 32'h10, 32'h0,  32'h11111111, 8'b00001000, 32'h10, 4'hf, 32'h11111111, 32'h0};
        tbl[11] = '{6'b000000, 32'h10, 32'h0,  32'h0,        8'b00000000, 32'h10, 4'hf, 32'h11111111, 32'h0};
        tbl[12] = '{6'b000100, 32'h10, 32'h14, 32'h0,        8'b01010010, 32'h14, 4'h0, 32'h11111111, 32'h0};
        tbl[13] = '{6'b000010, 32'h10, 32'h14, 32'h0,        8'b00010000, 32'h14, 4'h0, 32'h11111111, 32'h0};
        tbl[14] = '{6'b000001, 32'h10, 32'h14, 32'hbeefbeef, 8'b00000100, 32'h14, 4'h0, 32'h11111111, 32'hbeefbeef};
        tbl[15] = '{6'b000000, 32'h10, 32'h14, 32'h0,        8'b00000000, 32'h14, 4'h0, 32'h11111111, 32'hbeefbeef};
        quiet();
        p1_addr = '0; p2_addr = '0; p1_wdata = 32'hcafecafe; p1_wstrb = 4'hf;
        #2;
        for (int i = 0; i < 16; i++) begin
            {rst, p1_req, p1_we, p2_req, m_ack, m_done} = tbl[i].ctl;
            p1_addr = tbl[i].a1;
            p2_addr = tbl[i].a2;
            m_rdata = tbl[i].mrd;
            tick();
            chk32($sformatf("row%0d flags", i),
                  {24'h0, p1_gnt, p2_gnt, p1_busy, p2_busy, p1_rvalid, p2_rvalid, m_req},
                  {24'h0, tbl[i].flg[7:1]});
            if (tbl[i].flg[1]) begin
                chk1($sformatf("row%0d m_we", i), m_we, tbl[i].flg[0]);
                chk32($sformatf("row%0d m_addr", i), m_addr, tbl[i].maddr);
                chk32($sformatf("row%0d m_wstrb", i), {28'h0, m_wstrb}, {28'h0, tbl[i].mws});
                if (tbl[i].flg[0]) chk32($sformatf("row%0d m_wdata", i), m_wdata, 32'hcafecafe);
            end
            chk32($sformatf("row%0d p1_rdata", i), p1_rdata, tbl[i].rd1);
            chk32($sformatf("row%0d p2_rdata", i), p2_rdata, tbl[i].rd2);
        end

        // simultaneous requests after reset, then alternation
        quiet();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0; p1_req = 1'b1; p1_addr = 32'h20; p2_req = 1'b1; p2_addr = 32'h24;
        tick();
        chk1("sim p1_gnt", p1_gnt, 1'b1);
        chk1("sim p2_gnt", p2_gnt, 1'b0);
        chk32("sim m_addr", m_addr, 32'h20);
        chk1("sim m_we", m_we, 1'b0);
        p1_req = 1'b0; m_ack = 1'b1;
        tick();
        m_ack = 1'b0; m_done = 1'b1; m_rdata = 32'ha1a1a1a1;
        tick();
        chk1("sim p1_rvalid", p1_rvalid, 1'b1);
        chk32("sim p1_rdata", p1_rdata, 32'ha1a1a1a1);
        m_done = 1'b0; p1_req = 1'b1;
        tick();
        chk1("alt p2_gnt", p2_gnt, 1'b1);
        chk1("alt p1_gnt", p1_gnt, 1'b0);
        chk32("alt m_addr", m_addr, 32'h24);
        p2_req = 1'b0; m_ack = 1'b1;
        tick();
        m_ack = 1'b0; m_done = 1'b1; m_rdata = 32'hb2b2b2b2;
        tick();
        chk1("alt p2_rvalid", p2_rvalid, 1'b1);
        chk32("alt p2_rdata", p2_rdata, 32'hb2b2b2b2);
        chk32("alt p1_rdata held", p1_rdata, 32'ha1a1a1a1);
        m_done = 1'b0;
        tick();
        chk1("alt p1 regrant", p1_gnt, 1'b1);
        chk32("alt p1 m_addr", m_addr, 32'h20);
        p1_req = 1'b0; m_ack = 1'b1;
        tick();
        m_ack = 1'b0; m_done = 1'b1; m_rdata = 32'h0;
        tick();
        m_done = 1'b0;
        tick();

        // long outstanding p2 read while p1 waits
        p2_req = 1'b1; p2_addr = 32'h14;
        tick();
        chk1("dl p2_gnt", p2_gnt, 1'b1);
        p2_req = 1'b0; p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h30; m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        gnt_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (p1_gnt) gnt_seen++;
        end
        chk32("dl no early p1_gnt", gnt_seen, 0);
        m_done = 1'b1; m_rdata = 32'hcccccccc;
        tick();
        chk1("dl p2_rvalid", p2_rvalid, 1'b1);
        chk1("dl p1_gnt too early", p1_gnt, 1'b0);
        m_done = 1'b0;
        tick();
        chk1("dl p1_gnt", p1_gnt, 1'b1);
        chk32("dl m_addr", m_addr, 32'h30);
        p1_req = 1'b0; m_ack = 1'b1;
        tick();
        m_ack = 1'b0; m_done = 1'b1; m_rdata = 32'h5a5a5a5a;
        tick();
        chk1("dl p1_rvalid", p1_rvalid, 1'b1);
        chk32("dl p1_rdata", p1_rdata, 32'h5a5a5a5a);
        chk32("dl p2_rdata held", p2_rdata, 32'hcccccccc);
        m_done = 1'b0;
        tick();

        // reset while waiting for completion
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h40;
        tick();
        chk1("rw p1_gnt", p1_gnt, 1'b1);
        p1_req = 1'b0; m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk1("rw p1_busy", p1_busy, 1'b0);
        chk1("rw p1_rvalid", p1_rvalid, 1'b0);
        chk1("rw m_req", m_req, 1'b0);
        chk32("rw p1_rdata", p1_rdata, 32'h0);
        rst = 1'b0; m_done = 1'b1; m_rdata = 32'h77777777;
        tick();
        chk1("rw stray done p1_rvalid", p1_rvalid, 1'b0);
        chk1("rw stray done p2_rvalid", p2_rvalid, 1'b0);
        m_done = 1'b0; p2_req = 1'b1; p2_addr = 32'h44;
        tick();
        chk1("rw p2_gnt", p2_gnt, 1'b1);
        chk1("rw p2_busy", p2_busy, 1'b1);
        chk32("rw m_addr", m_addr, 32'h44);
        chk32("rw m_wstrb", {28'h0, m_wstrb}, 32'h0);
        p2_req = 1'b0; m_ack = 1'b1;
        tick();
        m_ack = 1'b0; m_done = 1'b1; m_rdata = 32'hdddddddd;
        tick();
        chk1("rw p2_rvalid", p2_rvalid, 1'b1);
        chk32("rw p2_rdata", p2_rdata, 32'hdddddddd);
        m_done = 1'b0;
        tick();
        chk1("rw p2_rvalid pulse", p2_rvalid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
